// File: rtl/ghost_pkg.sv
// Shared types and helpers for the ghost movement controller.
// Direction/mode encodings match the ghost instance's port encoding.
package ghost_pkg;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_UP    = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        MODE_SCATTER = 2'b00,
        MODE_CHASE   = 2'b01,
        MODE_FRIGHT  = 2'b10,
        MODE_HALT    = 2'b11
    } mode_t;

    localparam int PF_W    = 380;
    localparam int PF_H    = 432;
    localparam int TIMER_W = 16;

    // Opposite directions differ only in the top bit.
    function automatic dir_t reverseDir(input dir_t d);
        return dir_t'({~d[1], d[0]});
    endfunction

endpackage

// File: rtl/ghost_ai_ctrl_if.sv
// Game-state <-> ghost controller bundle.
// dots_left exists only when GHOST_ELROY_EN is defined.
interface ghost_ai_ctrl_if;

    logic [9:0] ghost_x;
    logic [9:0] ghost_y;
    logic [9:0] pacman_x;
    logic [9:0] pacman_y;
    logic       power_pellet;
    logic       touch_pac;
    logic [1:0] direction;
    logic [4:0] speed;
    logic [1:0] mode;
    logic       eaten;
    logic       caught;
`ifdef GHOST_ELROY_EN
    logic [7:0] dots_left;
`endif

    modport master (
        output ghost_x, ghost_y, pacman_x, pacman_y,
        output power_pellet, touch_pac,
`ifdef GHOST_ELROY_EN
        output dots_left,
`endif
        input  direction, speed, mode, eaten, caught
    );

    modport slave (
        input  ghost_x, ghost_y, pacman_x, pacman_y,
        input  power_pellet, touch_pac,
`ifdef GHOST_ELROY_EN
        input  dots_left,
`endif
        output direction, speed, mode, eaten, caught
    );

endinterface

// File: rtl/ghost_steer.sv
// Combinational direction choice: target, deltas, no-reverse rule,
// and the pseudo-random pick used while frightened.
module ghost_steer
    import ghost_pkg::*;
#(
    parameter logic [9:0] CORNER_X = 10'd370,
    parameter logic [9:0] CORNER_Y = 10'd10
) (
    input  mode_t      mode,
    input  logic       elroy,
    input  logic [9:0] ghostX,
    input  logic [9:0] ghostY,
    input  logic [9:0] pacX,
    input  logic [9:0] pacY,
    input  dir_t       curDir,
    input  logic [1:0] rnd,
    output dir_t       nextDir
);

    // Keep an out-of-field corner parameter inside the playfield.
    localparam logic [9:0] CX =
        (CORNER_X >= 10'(PF_W)) ? 10'(PF_W - 1) : CORNER_X;
    localparam logic [9:0] CY =
        (CORNER_Y >= 10'(PF_H)) ? 10'(PF_H - 1) : CORNER_Y;

    logic [9:0]        tgtX;
    logic [9:0]        tgtY;
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic [10:0]       adx;
    logic [10:0]       ady;
    logic              horiz;
    dir_t              hDir;
    dir_t              vDir;
    dir_t              prim;
    dir_t              sec;
    dir_t              rndDir;
    logic              frt;
    logic              still;
    logic              blocked;

    always_comb begin
        tgtX = CX;
        tgtY = CY;
        if (mode == MODE_CHASE || elroy) begin
            tgtX = pacX;
            tgtY = pacY;
        end
    end

    assign dx    = $signed({1'b0, tgtX}) - $signed({1'b0, ghostX});
    assign dy    = $signed({1'b0, tgtY}) - $signed({1'b0, ghostY});
    assign adx   = dx[10] ? $unsigned(-dx) : $unsigned(dx);
    assign ady   = dy[10] ? $unsigned(-dy) : $unsigned(dy);
    assign horiz = adx >= ady;

    // A zero delta falls through to right/down.
    assign hDir   = dx[10] ? DIR_LEFT : DIR_RIGHT;
    assign vDir   = dy[10] ? DIR_UP : DIR_DOWN;
    assign prim   = horiz ? hDir : vDir;
    assign sec    = horiz ? vDir : hDir;
    assign rndDir = dir_t'(rnd);

    assign frt     = mode == MODE_FRIGHT;
    assign still   = !frt && dx == '0 && dy == '0;
    assign blocked = !frt && !still && prim == reverseDir(curDir);

    always_comb begin
        nextDir = prim;
        unique case (1'b1)
            frt:
                nextDir = (rndDir == reverseDir(curDir))
                        ? dir_t'(rnd + 2'd1) : rndDir;
            still:   nextDir = curDir;
            blocked: nextDir = sec;
            default: nextDir = prim;
        endcase
    end

endmodule

// File: rtl/ghost_ai_ctrl.sv
// Per-ghost mode schedule, timers, LFSR and registered steering outputs.
// Optional GHOST_ELROY_EN adds dots_left speed-up / aggressive scatter.
module ghost_ai_ctrl
    import ghost_pkg::*;
#(
    parameter int         SCATTER_TICKS = 420,
    parameter int         CHASE_TICKS   = 1200,
    parameter int         N_SCATTER     = 3,
    parameter int         FRIGHT_TICKS  = 360,
    parameter int         DECIDE_PERIOD = 8,
    parameter logic [9:0] CORNER_X      = 10'd370,
    parameter logic [9:0] CORNER_Y      = 10'd10,
    parameter logic [4:0] NORMAL_SPEED  = 5'd2,
    parameter logic [4:0] FRIGHT_SPEED  = 5'd1,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
`ifdef GHOST_ELROY_EN
    ,
    parameter logic [7:0] ELROY_DOTS    = 8'd20
`endif
) (
    input logic             move_clk,
    input logic             reset,
    ghost_ai_ctrl_if.slave  bus
);

    localparam int TW = TIMER_W;
    localparam logic [TW-1:0] SC_END = TW'(SCATTER_TICKS - 1);
    localparam logic [TW-1:0] CH_END = TW'(CHASE_TICKS - 1);
    localparam logic [TW-1:0] FR_END = TW'(FRIGHT_TICKS - 1);
    localparam logic [7:0]    DEC_TOP = 8'(DECIDE_PERIOD - 1);
    localparam logic [7:0]    N_SC = 8'(N_SCATTER);
    localparam logic [4:0]    BOOST_SPEED =
        (NORMAL_SPEED == 5'd31) ? 5'd31 : NORMAL_SPEED + 5'd1;

    mode_t         modeQ, modeD;
    mode_t         savedQ, savedD;
    logic [TW-1:0] phaseQ, phaseD;
    logic [TW-1:0] frightQ, frightD;
    logic [7:0]    scatQ, scatD;
    logic [7:0]    decQ, decD;
    logic [7:0]    lfsrQ, lfsrD;
    dir_t          dirQ, dirD;
    dir_t          steerDir;
    logic [4:0]    speedQ, speedD;
    logic          eatenQ, eatenD;
    logic          caughtQ, caughtD;
    logic          revQ, revD;
    logic          trans;
    logic          elroy;
    logic          fb;

`ifdef GHOST_ELROY_EN
    assign elroy = bus.dots_left < ELROY_DOTS;
`else
    assign elroy = 1'b0;
`endif

    assign fb = lfsrQ[7] ^ lfsrQ[5] ^ lfsrQ[4] ^ lfsrQ[3];

    ghost_steer #(
        .CORNER_X (CORNER_X),
        .CORNER_Y (CORNER_Y)
    ) u_steer (
        .mode    (modeQ),
        .elroy   (elroy),
        .ghostX  (bus.ghost_x),
        .ghostY  (bus.ghost_y),
        .pacX    (bus.pacman_x),
        .pacY    (bus.pacman_y),
        .curDir  (dirQ),
        .rnd     (lfsrQ[1:0]),
        .nextDir (steerDir)
    );

    // Mode schedule: touch_pac > power_pellet > timer expiry.
    always_comb begin
        modeD   = modeQ;
        savedD  = savedQ;
        phaseD  = phaseQ;
        frightD = frightQ;
        scatD   = scatQ;
        eatenD  = 1'b0;
        caughtD = caughtQ;
        trans   = 1'b0;
        lfsrD   = {lfsrQ[6:0], fb};
        unique case (modeQ)
            MODE_HALT: modeD = MODE_HALT;
            MODE_FRIGHT: begin
                if (bus.touch_pac) begin
                    eatenD = 1'b1;
                    modeD  = savedQ;
                    trans  = 1'b1;
                end else if (bus.power_pellet) begin
                    frightD = '0;
                end else if (frightQ == FR_END) begin
                    modeD = savedQ;
                    trans = 1'b1;
                end else begin
                    frightD = frightQ + TW'(1);
                end
            end
            default: begin
                if (bus.touch_pac) begin
                    modeD   = MODE_HALT;
                    caughtD = 1'b1;
                end else if (bus.power_pellet) begin
                    savedD  = modeQ;
                    modeD   = MODE_FRIGHT;
                    frightD = '0;
                    trans   = 1'b1;
                end else if (modeQ == MODE_SCATTER) begin
                    if (phaseQ == SC_END) begin
                        modeD  = MODE_CHASE;
                        phaseD = '0;
                        scatD  = scatQ + 8'd1;
                        trans  = 1'b1;
                    end else begin
                        phaseD = phaseQ + TW'(1);
                    end
                end else if (phaseQ != CH_END) begin
                    phaseD = phaseQ + TW'(1);
                end else if (scatQ < N_SC) begin
                    modeD  = MODE_SCATTER;
                    phaseD = '0;
                    trans  = 1'b1;
                end
            end
        endcase
    end

    // A transition arms a reversal that lands on the following edge.
    always_comb begin
        dirD = dirQ;
        decD = decQ;
        revD = 1'b0;
        if (modeQ != MODE_HALT && modeD != MODE_HALT) begin
            if (trans) begin
                revD = 1'b1;
            end else if (revQ) begin
                dirD = reverseDir(dirQ);
                decD = DEC_TOP;
            end else if (decQ == '0) begin
                dirD = steerDir;
                decD = DEC_TOP;
            end else begin
                decD = decQ - 8'd1;
            end
        end
        unique case (modeD)
            MODE_HALT:   speedD = 5'd0;
            MODE_FRIGHT: speedD = FRIGHT_SPEED;
            default:     speedD = elroy ? BOOST_SPEED : NORMAL_SPEED;
        endcase
    end

    always_ff @(posedge move_clk) begin
        if (reset) begin
            modeQ   <= MODE_SCATTER;
            savedQ  <= MODE_SCATTER;
            phaseQ  <= '0;
            frightQ <= '0;
            scatQ   <= '0;
            decQ    <= '0;
            lfsrQ   <= LFSR_SEED;
            dirQ    <= DIR_LEFT;
            speedQ  <= NORMAL_SPEED;
            eatenQ  <= 1'b0;
            caughtQ <= 1'b0;
            revQ    <= 1'b0;
        end else begin
            modeQ   <= modeD;
            savedQ  <= savedD;
            phaseQ  <= phaseD;
            frightQ <= frightD;
            scatQ   <= scatD;
            decQ    <= decD;
            lfsrQ   <= lfsrD;
            dirQ    <= dirD;
            speedQ  <= speedD;
            eatenQ  <= eatenD;
            caughtQ <= caughtD;
            revQ    <= revD;
        end
    end

    assign bus.mode      = modeQ;
    assign bus.direction = dirQ;
    assign bus.speed     = speedQ;
    assign bus.eaten     = eatenQ;
    assign bus.caught    = caughtQ;

endmodule

// File: tb/tb_ghost_ai_ctrl.sv
// Directed + randomized bench for ghost_ai_ctrl against a behavioural
// model of the mode schedule and steering rules.
module tb_ghost_ai_ctrl;

    logic move_clk;
    logic reset;
    int   checks;
    int   failures;
    int   cyc;

    ghost_ai_ctrl_if bus();

    ghost_ai_ctrl dut (
        .move_clk (move_clk),
        .reset    (reset),
        .bus      (bus)
    );

    initial move_clk = 1'b0;
    always #5 move_clk = ~move_clk;

    // Model state: modes 0 scatter, 1 chase, 2 fright, 3 halt.
    int       mMode, mSaved, mPhase, mFright, mScat, mDec;
    int       mDir, mSpeed, mEaten, mCaught;
    bit       mRev;
    bit [7:0] mLfsr;

    function automatic int rev(input int d);
        return (d + 2) % 4;
    endfunction

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    function automatic int aimDir(input int mode, input int cur);
        int tx, ty, dx, dy, h, v, p, s;
        tx = (mode == 1) ? int'(bus.pacman_x) : 370;
        ty = (mode == 1) ? int'(bus.pacman_y) : 10;
        dx = tx - int'(bus.ghost_x);
        dy = ty - int'(bus.ghost_y);
        if (dx == 0 && dy == 0) return cur;
        h = (dx < 0) ? 0 : 2;
        v = (dy < 0) ? 1 : 3;
        p = (iabs(dx) >= iabs(dy)) ? h : v;
        s = (iabs(dx) >= iabs(dy)) ? v : h;
        return (p == rev(cur)) ? s : p;
    endfunction

    function automatic int randDir(input bit [7:0] l, input int cur);
        int r;
        r = int'(l & 8'd3);
        return (r == rev(cur)) ? (r + 1) % 4 : r;
    endfunction

    task automatic modelStep();
        int       nMode;
        bit       trans;
        bit [7:0] nl;
        if (reset) begin
            mMode = 0; mSaved = 0; mPhase = 0; mFright = 0; mScat = 0;
            mDec = 0; mLfsr = 8'hA5; mRev = 0; mDir = 0; mSpeed = 2;
            mEaten = 0; mCaught = 0;
            return;
        end
        nl = {mLfsr[6:0], ^(mLfsr & 8'hB8)};
        nMode = mMode;
        trans = 0;
        mEaten = 0;
        if (mMode != 3) begin
            if (bus.touch_pac) begin
                if (mMode == 2) begin
                    mEaten = 1; nMode = mSaved; trans = 1;
                end else begin
                    nMode = 3; mCaught = 1;
                end
            end else if (bus.power_pellet) begin
                if (mMode != 2) begin
                    mSaved = mMode; nMode = 2; trans = 1;
                end
                mFright = 0;
            end else if (mMode == 2) begin
                if (mFright == 359) begin
                    nMode = mSaved; trans = 1;
                end else mFright++;
            end else if (mMode == 0) begin
                if (mPhase == 419) begin
                    nMode = 1; mPhase = 0; mScat++; trans = 1;
                end else mPhase++;
            end else begin
                if (mPhase != 1199) mPhase++;
                else if (mScat < 3) begin
                    nMode = 0; mPhase = 0; trans = 1;
                end
            end
        end
        if (mMode == 3 || nMode == 3) mRev = 0;
        else if (trans) mRev = 1;
        else if (mRev) begin
            mDir = rev(mDir); mDec = 7; mRev = 0;
        end else if (mDec == 0) begin
            mDir = (mMode == 2) ? randDir(mLfsr, mDir) : aimDir(mMode, mDir);
            mDec = 7;
        end else mDec--;
        mMode = nMode;
        mSpeed = (nMode == 3) ? 0 : (nMode == 2) ? 1 : 2;
        mLfsr = nl;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        modelStep();
        @(posedge move_clk);
        #1;
        cyc++;
        check("mode", 32'(bus.mode), mMode);
        check("dir", 32'(bus.direction), mDir);
        check("speed", 32'(bus.speed), mSpeed);
        check("eaten", 32'(bus.eaten), mEaten);
        check("caught", 32'(bus.caught), mCaught);
    endtask

    task automatic setPos(input int gx, input int gy, input int px,
                          input int py);
        bus.ghost_x  = 10'(gx);
        bus.ghost_y  = 10'(gy);
        bus.pacman_x = 10'(px);
        bus.pacman_y = 10'(py);
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_mode"}, 32'(bus.mode), 0);
        check({tag, "_dir"}, 32'(bus.direction), 0);
        check({tag, "_speed"}, 32'(bus.speed), 2);
        check({tag, "_eaten"}, 32'(bus.eaten), 0);
        check({tag, "_caught"}, 32'(bus.caught), 0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        reset = 1'b1;
        bus.power_pellet = 1'b0;
        bus.touch_pac = 1'b0;
`ifdef GHOST_ELROY_EN
        bus.dots_left = 8'd200;
`endif
        setPos(200, 200, 100, 100);
        tick();
        tick();
        checkReset("rst");

        reset = 1'b0;
        cyc = 0;
        repeat (419) tick();
        check("scatter_419", 32'(bus.mode), 0);
        tick();
        check("chase_420", 32'(bus.mode), 1);
        check("chase_speed", 32'(bus.speed), 2);

        setPos(100, 100, 100, 300);
        repeat (24) tick();
        check("aim_down", 32'(bus.direction), 3);
        setPos(100, 100, 300, 120);
        repeat (8) tick();
        check("aim_right", 32'(bus.direction), 2);
        setPos(100, 100, 50, 110);
        repeat (8) tick();
        check("no_reverse", 32'(bus.direction), 3);

        repeat (920 - cyc) tick();
        bus.power_pellet = 1'b1;
        tick();
        bus.power_pellet = 1'b0;
        check("fright_mode", 32'(bus.mode), 2);
        check("fright_speed", 32'(bus.speed), 1);
        repeat (359) tick();
        check("fright_359", 32'(bus.mode), 2);
        tick();
        check("fright_end", 32'(bus.mode), 1);
        repeat (699) tick();
        check("resume_1199", 32'(bus.mode), 1);
        tick();
        check("resume_exp", 32'(bus.mode), 0);

        bus.power_pellet = 1'b1;
        tick();
        bus.power_pellet = 1'b0;
        repeat (50) tick();
        bus.touch_pac = 1'b1;
        tick();
        bus.touch_pac = 1'b0;
        check("eaten_hi", 32'(bus.eaten), 1);
        check("eaten_mode", 32'(bus.mode), 0);
        tick();
        check("eaten_lo", 32'(bus.eaten), 0);

        repeat (3000) begin
            setPos($urandom_range(379), $urandom_range(431),
                   $urandom_range(379), $urandom_range(431));
            bus.power_pellet = ($urandom_range(199) == 0);
            tick();
        end
        bus.power_pellet = 1'b0;
        for (int i = 0; i < 400 && bus.mode == 2'd2; i++) tick();
        check("left_fright", 32'(bus.mode == 2'd2), 0);

        bus.touch_pac = 1'b1;
        tick();
        bus.touch_pac = 1'b0;
        check("halt_mode", 32'(bus.mode), 3);
        check("halt_speed", 32'(bus.speed), 0);
        check("halt_caught", 32'(bus.caught), 1);
        repeat (20) begin
            bus.power_pellet = ($urandom_range(3) == 0);
            bus.touch_pac = ($urandom_range(3) == 0);
            tick();
        end
        check("halt_hold", 32'(bus.mode), 3);

        reset = 1'b1;
        bus.touch_pac = 1'b1;
        bus.power_pellet = 1'b0;
        tick();
        checkReset("rst2");
        reset = 1'b0;
        bus.touch_pac = 1'b0;
        tick();
        bus.touch_pac = 1'b1;
        bus.power_pellet = 1'b1;
        tick();
        bus.touch_pac = 1'b0;
        bus.power_pellet = 1'b0;
        check("both_halt", 32'(bus.mode), 3);
        check("both_caught", 32'(bus.caught), 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
